led_bank_arbiter: RTL and testbench

- Shares the board's 8-bit LED bank between several on-chip requesters, e.g. SoC GPIO, a heartbeat generator and a status/fault indicator.
- Uses round-robin arbitration with a minimum display hold, so short pulses stay visible, and an optional maximum hold that preempts a long-running owner when others are waiting.
- Sits between the requesters and the LED output buffers.
- Output is logical active-high; pad inversion stays in the top-level wrapper.

---
 rtl/led_arb_pkg.sv | 28 ++
 rtl/led_bank_arbiter_rr_pick.sv | 29 ++
 rtl/led_bank_arbiter.sv | 131 +++++++++++++
 tb/tb_led_bank_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and elaboration helpers for the LED bank arbiter.
// Widths are derived from the parent's parameters via constant functions.
package led_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  function automatic int hold_sat(input int min_hold, input int max_hold);
    return (max_hold > min_hold) ? max_hold : min_hold;
  endfunction

  function automatic int hold_cnt_w(input int min_hold, input int max_hold);
    return $clog2(hold_sat(min_hold, max_hold) + 1);
  endfunction

  function automatic int owner_w(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  function automatic bit params_legal(input int n_req, input int w,
                                      input int min_hold, input int max_hold);
    return (n_req >= 2) && (n_req <= 8) && (w >= 1) && (min_hold >= 1) &&
           ((max_hold == 0) || (max_hold >= min_hold));
  endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'start' (wrapping)
// that is requesting and not masked out by 'excl'.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    start,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [OW-1:0]    idx
);

  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    // k runs 1..N_REQ so 'start' itself is visited last
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(start) + k) % N_REQ;
      if (!found && req[c] && !excl[c]) begin
        found = 1'b1;
        idx   = OW'(c);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 8-bit LED bank with minimum display hold and
// optional max-hold preemption. Outputs are logical active-high.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int             N_REQ        = 4,
  parameter int             W            = 8,
  parameter int             MIN_HOLD     = 4,
  parameter int             MAX_HOLD     = 16,
  parameter logic [W-1:0]   IDLE_PATTERN = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         data,
  output logic [N_REQ-1:0]           gnt,
  output logic [owner_w(N_REQ)-1:0]  owner,
  output logic                       active,
  output logic [W-1:0]               led,
  output arb_state_e                 dbg_state
);

  localparam int OW   = owner_w(N_REQ);
  localparam int HC_W = hold_cnt_w(MIN_HOLD, MAX_HOLD);
  localparam logic [HC_W-1:0] MIN_C = HC_W'(MIN_HOLD);
  localparam logic [HC_W-1:0] MAX_C = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] SAT_C = HC_W'(hold_sat(MIN_HOLD, MAX_HOLD));

  if (!params_legal(N_REQ, W, MIN_HOLD, MAX_HOLD)) begin : g_bad_params
    $error("led_bank_arbiter: illegal N_REQ/W/MIN_HOLD/MAX_HOLD combination");
  end

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [W-1:0]      led_q, led_d;
  logic [HC_W-1:0]   hold_q, hold_d;

  logic [N_REQ-1:0]  excl;
  logic              pick_found;
  logic [OW-1:0]     pick_idx;
  logic              own_req;
  logic              release_now;

  // While owning, gnt is the one-hot of the owner, so it doubles as the
  // exclusion mask for the re-pick on release.
  assign excl = (state_q == ST_OWN) ? gnt_q : '0;

  rr_pick #(.N_REQ(N_REQ), .OW(OW)) u_pick (
    .req   (req),
    .start (last_q),
    .excl  (excl),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign own_req     = req[owner_q];
  assign release_now = (!own_req && (hold_q >= MIN_C)) ||
                       ((MAX_HOLD != 0) && (hold_q >= MAX_C) && (|(req & ~gnt_q)));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    led_d   = led_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OWN;
          gnt_d   = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = HC_W'(1);
          led_d   = data[pick_idx*W +: W];
        end
      end
      ST_OWN: begin
        if (release_now && pick_found) begin
          gnt_d   = N_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = HC_W'(1);
          led_d   = data[pick_idx*W +: W];
        end else if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          hold_d  = '0;
          led_d   = IDLE_PATTERN;
        end else begin
          if (hold_q < SAT_C) hold_d = hold_q + 1'b1;
          // A dropped request freezes the LED at its last captured pattern
          if (own_req) led_d = data[owner_q*W +: W];
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        hold_d  = '0;
        led_d   = IDLE_PATTERN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N_REQ - 1);
      led_q   <= IDLE_PATTERN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      led_q   <= led_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign active    = (state_q == ST_OWN);
  assign led       = led_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: a per-cycle vector table plus
// hand-written round-robin, preemption, saturation and async-reset sequences.
module tb_led_bank_arbiter;
  import led_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        active;
  logic [7:0]  led;
  arb_state_e  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  led_bank_arbiter #(
    .N_REQ(4), .W(8), .MIN_HOLD(4), .MAX_HOLD(16), .IDLE_PATTERN(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .owner     (owner),
    .active    (active),
    .led       (led),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    step();
    rst  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        act;
    logic [1:0]  own;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[22];
  logic [1:0] rr_order[5];

  initial begin
    // single request, data tracking, drop -> idle
    vecs[0]  = '{4'b0100, 32'h00A50000, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vecs[1]  = '{4'b0100, 32'h00A50000, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vecs[2]  = '{4'b0100, 32'h00A50000, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vecs[3]  = '{4'b0100, 32'h00A50000, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vecs[4]  = '{4'b0100, 32'h00A60000, 4'b0100, 1'b1, 2'd2, 8'hA6};
    vecs[5]  = '{4'b0000, 32'h00A70000, 4'b0000, 1'b0, 2'd0, 8'h00};
    vecs[6]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'h00};
    // one-cycle pulse on req[1]: held 4 cycles with frozen LED
    vecs[7]  = '{4'b0010, 32'h00003C00, 4'b0010, 1'b1, 2'd1, 8'h3C};
    vecs[8]  = '{4'b0000, 32'h0000FF00, 4'b0010, 1'b1, 2'd1, 8'h3C};
    vecs[9]  = '{4'b0000, 32'h0000FF00, 4'b0010, 1'b1, 2'd1, 8'h3C};
    vecs[10] = '{4'b0000, 32'h0000FF00, 4'b0010, 1'b1, 2'd1, 8'h3C};
    vecs[11] = '{4'b0000, 32'h0000FF00, 4'b0000, 1'b0, 2'd0, 8'h00};
    vecs[12] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd0, 8'h00};
    // owner 1 data change, non-owner data ignored, handover to 0
    vecs[13] = '{4'b0010, 32'h00000100, 4'b0010, 1'b1, 2'd1, 8'h01};
    vecs[14] = '{4'b0010, 32'h000002FF, 4'b0010, 1'b1, 2'd1, 8'h02};
    vecs[15] = '{4'b0011, 32'h00000277, 4'b0010, 1'b1, 2'd1, 8'h02};
    vecs[16] = '{4'b0010, 32'h00000255, 4'b0010, 1'b1, 2'd1, 8'h02};
    vecs[17] = '{4'b0001, 32'h00009966, 4'b0001, 1'b1, 2'd0, 8'h66};
    vecs[18] = '{4'b0001, 32'h00009967, 4'b0001, 1'b1, 2'd0, 8'h67};
    vecs[19] = '{4'b0000, 32'h00000068, 4'b0001, 1'b1, 2'd0, 8'h67};
    vecs[20] = '{4'b0000, 32'h00000068, 4'b0001, 1'b1, 2'd0, 8'h67};
    vecs[21] = '{4'b0000, 32'h00000068, 4'b0000, 1'b0, 2'd0, 8'h00};
    rr_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // reset values, observed while reset is held
    rst = 1'b1; req = '0; data = '0;
    #3;
    chk("reset gnt",    32'(gnt), 32'h0);
    chk("reset active", 32'(active), 32'h0);
    chk("reset led",    32'(led), 32'h00);
    chk("reset state",  32'(dbg_state), 32'(ST_IDLE));
    step();
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 22; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      step();
      chk($sformatf("v%0d gnt", i),    32'(gnt),    32'(vecs[i].gnt));
      chk($sformatf("v%0d active", i), 32'(active), 32'(vecs[i].act));
      chk($sformatf("v%0d led", i),    32'(led),    32'(vecs[i].led));
      if (vecs[i].act)
        chk($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].own));
    end

    // round-robin: all requesting, each owner drops after 5 cycles
    do_reset();
    data = 32'h44332211;
    req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 5; c++) begin
        step();
        chk($sformatf("rr k%0d c%0d gnt", k, c), 32'(gnt), 32'(4'b0001 << rr_order[k]));
        chk($sformatf("rr k%0d c%0d led", k, c), 32'(led), 32'(8'h11 * (rr_order[k] + 1)));
        if (c == 0 && k > 0) req[rr_order[k-1]] = 1'b1;
      end
      req[rr_order[k]] = 1'b0;
    end

    // preemption: owner 0 keeps 16 cycles, then requester 3 takes over
    do_reset();
    data = 32'h88000011;
    req  = 4'b0001;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk($sformatf("pre c%0d gnt", c), 32'(gnt), 32'h1);
      if (c == 3) req = 4'b1001;
    end
    step();
    chk("pre handover gnt",   32'(gnt), 32'h8);
    chk("pre handover owner", 32'(owner), 32'h3);
    chk("pre handover led",   32'(led), 32'h88);

    // sole requester for 40 cycles: no preemption, counter saturates
    do_reset();
    data = 32'h00CC0011;
    req  = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      step();
      chk($sformatf("sat c%0d gnt", c), 32'(gnt), 32'h1);
    end
    req = 4'b0101;
    step();
    chk("sat preempt gnt", 32'(gnt), 32'h4);
    chk("sat preempt led", 32'(led), 32'hCC);

    // asynchronous reset in the middle of a grant
    #3 rst = 1'b1;
    #1;
    chk("async rst gnt",    32'(gnt), 32'h0);
    chk("async rst active", 32'(active), 32'h0);
    chk("async rst led",    32'(led), 32'h00);
    chk("async rst state",  32'(dbg_state), 32'(ST_IDLE));
    #1 rst = 1'b0;
    req = 4'b1000;
    data = 32'h5A000000;
    step();
    chk("post rst gnt", 32'(gnt), 32'h8);
    chk("post rst led", 32'(led), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
